// File: rtl/mac_accumulator.sv
// Frame accumulator: sums N_SAMPLES unsigned samples with saturation; result valid 1 cycle after last sample.
// Result is held in HOLD until out_valid&&out_ready; start with that handshake chains straight into the next frame.
module mac_accumulator #(
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       sample_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [7:0]       LAST_CNT = 8'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    // One extra bit catches the carry that signals saturation.
    sum_ext     = {1'b0, acc_q} + (ACC_W + 1)'(in_data);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          acc_d      = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (sum_ext[ACC_W]) begin
            acc_d      = ACC_MAX;
            overflow_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d     = HOLD;
            out_sum_d   = acc_d;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == ACCUM);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (N=16, 17, 1) share stimulus and are checked every cycle against a frame model.
module tb_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, out_ready;
  logic [15:0] in_data;

  logic        o_vld [3];
  logic [19:0] o_sum [3];
  logic        o_ovf [3];
  logic        o_busy[3];
  logic [7:0]  o_cnt [3];

  mac_accumulator #(.N_SAMPLES(16), .ACC_W(20)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(o_vld[0]), .out_sum(o_sum[0]), .overflow(o_ovf[0]),
    .busy(o_busy[0]), .sample_cnt(o_cnt[0]));

  mac_accumulator #(.N_SAMPLES(17), .ACC_W(20)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(o_vld[1]), .out_sum(o_sum[1]), .overflow(o_ovf[1]),
    .busy(o_busy[1]), .sample_cnt(o_cnt[1]));

  mac_accumulator #(.N_SAMPLES(1), .ACC_W(20)) u2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(o_vld[2]), .out_sum(o_sum[2]), .overflow(o_ovf[2]),
    .busy(o_busy[2]), .sample_cnt(o_cnt[2]));

  localparam longint MAXV = 1048575;
  int ns[3] = '{16, 17, 1};

  // Frame model: 0 = waiting for start, 1 = collecting, 2 = result offered
  int     m_phase[3];
  longint m_acc  [3];
  int     m_cnt  [3];
  longint m_osum [3];
  bit     m_ovld [3];
  bit     m_ovf  [3];
  bit     armed = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_phase[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
        m_osum[i] = 0;  m_ovld[i] = 0; m_ovf[i] = 0;
      end else begin
        case (m_phase[i])
          0: if (start) begin
               m_phase[i] = 1; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
             end
          1: if (in_valid) begin
               m_acc[i] = m_acc[i] + longint'(in_data);
               if (m_acc[i] > MAXV) begin
                 m_acc[i] = MAXV;
                 m_ovf[i] = 1;
               end
               m_cnt[i]++;
               if (m_cnt[i] == ns[i]) begin
                 m_phase[i] = 2; m_osum[i] = m_acc[i]; m_ovld[i] = 1;
               end
             end
          default: if (out_ready) begin
               m_ovld[i] = 0;
               if (start) begin
                 m_phase[i] = 1; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
               end else begin
                 m_phase[i] = 0;
               end
             end
        endcase
      end
    end
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.out_valid", i),  64'(o_vld[i]),  64'(m_ovld[i]));
        chk($sformatf("u%0d.out_sum", i),    64'(o_sum[i]),  64'(m_osum[i]));
        chk($sformatf("u%0d.overflow", i),   64'(o_ovf[i]),  64'(m_ovf[i]));
        chk($sformatf("u%0d.busy", i),       64'(o_busy[i]), 64'(m_phase[i] == 1));
        chk($sformatf("u%0d.sample_cnt", i), 64'(o_cnt[i]),  64'(m_cnt[i]));
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit v, input logic [15:0] d, input bit rdy);
    reset = r; start = s; in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 16'd9, 1);
    chk("reset.out_valid", o_vld[0], 0);
    chk("reset.out_sum", o_sum[0], 0);
    chk("reset.busy", o_busy[0], 0);
    chk("reset.sample_cnt", o_cnt[0], 0);

    // basic frame
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 1, 16'd100, 0);
      chk("basic.latency", o_vld[0], k == 15);
    end
    chk("basic.out_sum", o_sum[0], 1600);
    chk("basic.overflow", o_ovf[0], 0);
    chk("basic.sample_cnt", o_cnt[0], 16);
    chk("model.basic_sum", m_osum[0], 1600);
    chk("n1.out_sum", o_sum[2], 100);
    cyc(0, 0, 0, 0, 1);
    chk("basic.handshake_vld", o_vld[0], 0);
    chk("basic.handshake_busy", o_busy[0], 0);

    // gaps on in_valid
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    acc = 0;
    for (int k = 0; k < 32; k++) begin
      cyc(0, 0, (k % 2) == 0, 16'hFFFF, 0);
      if ((k % 2) == 0) acc++;
      chk("gaps.latency", o_vld[0], acc == 16);
    end
    chk("gaps.out_sum", o_sum[0], 1048560);
    chk("gaps.overflow", o_ovf[0], 0);

    // saturation on the 17-sample instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 17; k++) cyc(0, 0, 1, 16'hFFFF, 0);
    chk("sat.out_sum", o_sum[1], 1048575);
    chk("sat.overflow", o_ovf[1], 1);
    chk("sat.out_valid", o_vld[1], 1);
    chk("model.sat_sum", m_osum[1], 1048575);
    cyc(0, 1, 0, 0, 1);
    chk("sat.overflow_cleared", o_ovf[1], 0);
    chk("sat.busy_again", o_busy[1], 1);

    // backpressure then back-to-back
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 16'd7, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk("bp.out_sum", o_sum[0], 112);
      chk("bp.out_valid", o_vld[0], 1);
    end
    cyc(0, 1, 0, 0, 1);
    chk("b2b.busy", o_busy[0], 1);
    chk("b2b.sample_cnt", o_cnt[0], 0);
    chk("b2b.out_valid", o_vld[0], 0);

    // reset mid-frame, reset wins over everything
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 16'd3, 0);
    cyc(1, 1, 1, 16'd3, 1);
    chk("midrst.out_valid", o_vld[0], 0);
    chk("midrst.out_sum", o_sum[0], 0);
    chk("midrst.overflow", o_ovf[0], 0);
    chk("midrst.busy", o_busy[0], 0);
    chk("midrst.sample_cnt", o_cnt[0], 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 16'd1, 0);
    chk("midrst.new_sum", o_sum[0], 16);
    chk("midrst.new_vld", o_vld[0], 1);

    // ignored inputs in IDLE, ACCUM and HOLD
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 16'd500, 0);
    cyc(0, 0, 1, 16'd500, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, (k % 4) == 2, 1, 16'd10, 0);
    chk("ign.accum_sum", o_sum[0], 160);
    cyc(0, 0, 1, 16'd500, 0);
    cyc(0, 1, 1, 16'd500, 0);
    chk("ign.hold_sum", o_sum[0], 160);
    chk("ign.hold_cnt", o_cnt[0], 16);
    chk("ign.hold_vld", o_vld[0], 1);
    chk("ign.hold_busy", o_busy[0], 0);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 1) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, d, $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter N_SAMPLES, default 16, sets the samples per accumulation frame; legal range 1..255.
REQ-002 Parameter ACC_W, default 20, sets the accumulator and result width in bits; legal range 17..32.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle pulse that opens a new accumulation frame.
REQ-006 in_valid  input  1  in_data qualifier, driven by the upstream multiply-add stage.
REQ-007 in_data  input  16  unsigned sample, A*B+C result from the upstream stage.
REQ-008 out_ready  input  1  downstream accept for out_sum.
REQ-009 out_valid  output  1  out_sum holds a completed frame result.
REQ-010 out_sum  output  ACC_W  saturated unsigned frame sum.
REQ-011 overflow  output  1  sticky flag; set when saturation occurred in the current or last frame.
REQ-012 busy  output  1  high while in state ACCUM.
REQ-013 sample_cnt  output  8  samples accepted in the current frame.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and HOLD, with IDLE as the reset state.
REQ-015 IDLE SHALL move to ACCUM on start=1 and, on that edge, clear acc, sample_cnt and overflow.
REQ-016 In ACCUM, each cycle with in_valid=1 SHALL add zero-extended in_data to acc and increment sample_cnt.
REQ-017 Cycles with in_valid=0 SHALL leave acc and sample_cnt unchanged.
REQ-018 The sum SHALL saturate: if acc+in_data > 2^ACC_W-1, acc becomes 2^ACC_W-1 and overflow is set.
REQ-019 Once saturated, acc SHALL stay at max and overflow SHALL stay set until the next frame start or reset.
REQ-020 The edge accepting the N_SAMPLES-th sample SHALL move the FSM to HOLD.
REQ-021 On that same edge, out_sum SHALL load the final acc and out_valid SHALL go to 1.
REQ-022 Latency SHALL be exactly 1 cycle from the last accepted sample to out_valid=1.
REQ-023 In HOLD, out_valid, out_sum and overflow SHALL stay stable until out_valid&&out_ready.
REQ-024 A handshake in HOLD SHALL move the FSM to IDLE and clear out_valid.
REQ-025 Handshake plus start=1 in the same HOLD cycle SHALL move the FSM directly to ACCUM with a cleared frame, giving zero idle cycles.
REQ-026 start in ACCUM SHALL be ignored; start in HOLD without the handshake SHALL be ignored.
REQ-027 in_valid outside ACCUM SHALL be ignored, so those samples are dropped and not counted.
REQ-028 With N_SAMPLES=1, the first accepted sample SHALL go straight to HOLD.
REQ-029 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-030 sample_cnt SHALL read N_SAMPLES in HOLD and 0 after reset.
REQ-031 busy SHALL equal (state==ACCUM).

Reset
REQ-032 reset=1 SHALL force on the next edge: state IDLE, acc 0, sample_cnt 0, out_sum 0, out_valid 0, overflow 0, busy 0.
REQ-033 reset SHALL take priority over start, in_valid and out_ready in the same cycle.
REQ-034 Reset mid-ACCUM or mid-HOLD SHALL abandon the frame, so no out_valid is produced for it.
REQ-035 Outputs SHALL be deterministic from the first edge with reset=1; no reset of the upstream stage is required.

Verification
REQ-036 Basic frame (defaults): start, then 16 valid samples of value 100 -> next cycle out_valid=1, out_sum=1600, overflow=0, sample_cnt=16.
REQ-037 Gaps: 16 samples of 65535 with in_valid toggling every cycle -> out_sum=1048560, overflow=0, and out_valid exactly 1 cycle after the 16th accepted sample.
REQ-038 Saturation (N_SAMPLES=17): 17 samples of 65535 -> out_sum=1048575, overflow=1; overflow clears on the next start.
REQ-039 Backpressure and back-to-back: hold out_ready=0 for 5 cycles in HOLD -> out_sum stable; then out_ready=1 with start=1 -> next edge busy=1, sample_cnt=0, out_valid=0.
REQ-040 Reset mid-frame: reset=1 after 7 samples -> all outputs 0; a new start and 16 samples of 1 -> out_sum=16.
REQ-041 Ignored inputs: in_valid=1 with data 500 in IDLE and in HOLD, and start pulsed in ACCUM -> frame sum and sample_cnt unaffected.
